// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract sequencer: one 4-bit nibble per clock, LSB first, carry registered between nibbles.
// Optional build macro NIBBLE_SERIAL_ADDSUB_SAT_EN clamps a signed overflow to signed saturation.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);
    // state | meaning
    // IDLE  | waiting for an operand request, in_ready high
    // RUN   | one nibble per edge through the slice, LSB first
    // DONE  | result presented, held until out_ready
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
            $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // 4-bit add/sub slice: {cout, sum} = a + (b ^ {4{sub}}) + cin
    function automatic logic [4:0] slice_add(input logic [3:0] a, input logic [3:0] b,
                                             input logic sub, input logic cin);
        slice_add = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0000, cin};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             sub_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;

    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             a_msb;
    logic             b_msb_eff;
    logic             final_ovf;
    logic [WIDTH-1:0] final_res;

    always_comb begin
        {slice_cout, slice_sum} = slice_add(a_reg[{cnt, 2'b00} +: 4], b_reg[{cnt, 2'b00} +: 4],
                                            sub_reg, carry);
    end

    assign a_msb     = a_reg[WIDTH-1];
    assign b_msb_eff = b_reg[WIDTH-1] ^ sub_reg;
    assign final_ovf = (a_msb == b_msb_eff) && (slice_sum[3] != a_msb);

    // Full result as it will stand once the top nibble lands this edge
    always_comb begin
        final_res              = res_reg;
        final_res[WIDTH-1 -: 4] = slice_sum;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        if (final_ovf) begin
            final_res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            sub_reg  <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        sub_reg <= in_sub;
                        cnt     <= '0;
                        carry   <= in_sub;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    carry <= slice_cout;
                    if (cnt == LAST_CNT) begin
                        res_reg  <= final_res;
                        cout_reg <= slice_cout;
                        ovf_reg  <= final_ovf;
                        zero_reg <= (final_res == '0);
                        cnt      <= '0;
                        state    <= DONE;
                    end else begin
                        res_reg[{cnt, 2'b00} +: 4] <= slice_sum;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_res   = res_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;
    assign out_zero  = zero_reg;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed self-checking bench for nibble_serial_addsub (WIDTH=16).
// Expectations follow NIBBLE_SERIAL_ADDSUB_SAT_EN if the bench is built with it.
module tb_nibble_serial_addsub;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_res;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             busy;

    int tests_run = 0;
    int tests_failed = 0;

    nibble_serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Accept one request, then count edges until out_valid (bounded); 99 means timeout.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          output int lat, output bit between_ok);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        between_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) between_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({out_valid, in_ready, busy, out_res, out_cout, out_ovf, out_zero} !== {1'b0, 1'b1, 1'b0, 16'h0000, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset: valid=%b ready=%b busy=%b res=%h flags=%b%b%b required 0 1 0 0000 000",
                     out_valid, in_ready, busy, out_res, out_cout, out_ovf, out_zero);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat; bit btw;
        run_op(16'h1234, 16'h0FFF, 1'b0, lat, btw);
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL add_latency: got %0d required 4", lat); end
        tests_run++;
        if (btw !== 1'b1) begin tests_failed++; $display("FAIL add_ready_busy_in_run: in_ready/busy wrong during RUN"); end
        tests_run++;
        if ({out_res, out_cout, out_ovf, out_zero} !== {16'h2233, 3'b000}) begin
            tests_failed++;
            $display("FAIL add_result: res=%h c=%b v=%b z=%b required 2233 0 0 0", out_res, out_cout, out_ovf, out_zero);
        end
        consume();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_handshake: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_pos_ovf();
        int lat; bit btw;
        logic [WIDTH-1:0] exp_res;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        exp_res = 16'h7FFF;
`else
        exp_res = 16'h8000;
`endif
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, btw);
        tests_run++;
        if (lat !== 4 || out_res !== exp_res || out_ovf !== 1'b1 || out_cout !== 1'b0 || out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL pos_ovf: lat=%0d res=%h c=%b v=%b z=%b required 4 %h 0 1 0",
                     lat, out_res, out_cout, out_ovf, out_zero, exp_res);
        end
        consume();
    endtask

    task automatic test_sub_zero();
        int lat; bit btw;
        run_op(16'h0005, 16'h0005, 1'b1, lat, btw);
        tests_run++;
        if (lat !== 4 || {out_res, out_cout, out_ovf, out_zero} !== {16'h0000, 3'b101}) begin
            tests_failed++;
            $display("FAIL sub_zero: lat=%0d res=%h c=%b v=%b z=%b required 4 0000 1 0 1",
                     lat, out_res, out_cout, out_ovf, out_zero);
        end
        consume();
    endtask

    task automatic test_sub_borrow();
        int lat; bit btw;
        run_op(16'h0003, 16'h0005, 1'b1, lat, btw);
        tests_run++;
        if (lat !== 4 || {out_res, out_cout, out_ovf, out_zero} !== {16'hFFFE, 3'b000}) begin
            tests_failed++;
            $display("FAIL sub_borrow: lat=%0d res=%h c=%b v=%b z=%b required 4 fffe 0 0 0",
                     lat, out_res, out_cout, out_ovf, out_zero);
        end
        consume();
    endtask

    task automatic test_neg_ovf();
        int lat; bit btw;
        logic [WIDTH-1:0] exp_res;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
        exp_res = 16'h8000;
`else
        exp_res = 16'h7FFF;
`endif
        run_op(16'h8000, 16'h0001, 1'b1, lat, btw);
        tests_run++;
        if (lat !== 4 || out_res !== exp_res || out_ovf !== 1'b1 || out_cout !== 1'b1 || out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL neg_ovf: lat=%0d res=%h c=%b v=%b z=%b required 4 %h 1 1 0",
                     lat, out_res, out_cout, out_ovf, out_zero, exp_res);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat; bit btw;
        run_op(16'h1234, 16'h0FFF, 1'b0, lat, btw);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a = in_a ^ 16'hFFFF;
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_res, out_cout, out_ovf, out_zero} !== {16'h2233, 3'b000}) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b res=%h flags=%b%b%b required 1 0 2233 000",
                         i, out_valid, in_ready, out_res, out_cout, out_ovf, out_zero);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: ready=%b busy=%b valid=%b required 1 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; bit btw;
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, in_ready, busy, out_res, out_cout, out_ovf, out_zero} !== {1'b0, 1'b1, 1'b0, 16'h0000, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_mid_run: valid=%b ready=%b busy=%b res=%h flags=%b%b%b required 0 1 0 0000 000",
                     out_valid, in_ready, busy, out_res, out_cout, out_ovf, out_zero);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, lat, btw);
        tests_run++;
        if (lat !== 4 || {out_res, out_cout, out_ovf, out_zero} !== {16'h0100, 3'b000}) begin
            tests_failed++;
            $display("FAIL after_reset_add: lat=%0d res=%h c=%b v=%b z=%b required 4 0100 0 0 0",
                     lat, out_res, out_cout, out_ovf, out_zero);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_pos_ovf();
        test_sub_zero();
        test_sub_borrow();
        test_neg_ovf();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle signed/unsigned add/subtract sequencer that drives a 4-bit add/sub slice for WIDTH-bit operands.
- Processes one nibble per clock, least significant first, and registers the carry between nibbles.
- Valid/ready on input and output. Sits between the operand source and the result consumer, ahead of the 4-bit add/sub datapath.
- The 4-bit slice is instantiated internally. Subtract works as B xor sub, with carry-in = sub on nibble 0.

Parameters:
- WIDTH, 16, operand/result width; a multiple of 4 and at least 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived local parameter: number of nibble cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept request
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_res  output  WIDTH  result
- out_cout  output  1  final carry out (for subtract: 1 = no borrow)
- out_ovf  output  1  signed overflow
- out_zero  output  1  out_res == 0
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, slice counter=0, carry reg=0.
  - out_valid=0, out_res=0, out_cout=0, out_ovf=0, out_zero=0, busy=0.
  - in_ready=1, since it is decoded from state IDLE.
- Reset mid-operation: the operation is dropped with no output, and the block returns to IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a, in_b, in_sub; counter=0; carry=in_sub; go RUN.
  - RUN: in_ready=0. Each edge computes nibble[cnt] = A[cnt] + (B[cnt] xor {4{sub}}) + carry, writes it into the result reg, stores cout into the carry reg, then cnt++. On the edge processing cnt==NSLICE-1:
    - register out_cout = slice cout;
    - register out_ovf = (A_msb == B'_msb) && (R_msb != A_msb), where B' = B xor sub;
    - register out_zero from the full result;
    - go DONE.
  - DONE: out_valid=1. out_res and flags stay stable until out_ready=1. On out_valid&&out_ready, go IDLE and clear out_valid.
- Latency: out_valid is observed high exactly NSLICE rising edges after the accepting edge. WIDTH=16 gives 4 edges.
- Throughput: at most one operation per NSLICE+2 cycles. in_ready is never high outside IDLE, so there is no overlap of accept with DONE.
- in_valid/operand changes during RUN/DONE are ignored; the latched operands are used.
- out_ready held high continuously: the result is still presented for exactly one cycle.
- out_ready asserted in IDLE/RUN has no effect.
- Arithmetic:
  - Modulo 2^WIDTH; the result wraps unless the optional feature is enabled.
  - out_cout is unsigned carry/no-borrow. out_ovf is two's-complement overflow.
- Output registers keep their last value in IDLE. Only out_valid qualifies them.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDSUB_SAT_EN.
- Defined: when signed overflow is detected on the final nibble, out_res is clamped to signed saturation.
  - A_msb=0 gives 0111..1; A_msb=1 gives 100..0.
  - out_ovf still reads 1, out_zero is computed on the clamped value, out_cout is unchanged.
  - Clamping is applied on the same final RUN edge, so latency is unchanged.
- Undefined: the result wraps and no clamp logic is present.

Test Plan:
- Add: WIDTH=16, in_a=0x1234, in_b=0x0FFF, in_sub=0.
  - Result: out_res=0x2233, cout=0, ovf=0, zero=0.
  - Timing: out_valid high 4 edges after the accept; in_ready=0 and busy=1 in between.
- Positive overflow: 0x7FFF+0x0001.
  - Without macro: out_res=0x8000, ovf=1, cout=0.
  - With NIBBLE_SERIAL_ADDSUB_SAT_EN: out_res=0x7FFF, ovf=1.
- Subtract, zero and borrow:
  - 0x0005-0x0005 gives out_res=0x0000, zero=1, cout=1.
  - 0x0003-0x0005 gives out_res=0xFFFE, cout=0, ovf=0.
- Negative overflow: 0x8000-0x0001.
  - Without macro: out_res=0x7FFF, ovf=1, cout=1.
  - With macro: out_res=0x8000, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and in_a.
  - Required: out_res/flags stable, in_ready=0, no new accept.
  - The cycle after out_ready=1, state returns to IDLE with in_ready=1.
- Reset mid-RUN: assert rst_n=0 after 2 nibble edges.
  - Required: all outputs immediately at reset values.
  - A following 0x00FF+0x0001 gives 0x0100 with correct 4-edge latency.
